// File: rtl/relm_ps2_pkg.sv
// relm_ps2_pkg: states, frame geometry, command/reply bytes and parity
// helper shared by the PS/2 device endpoint.
package relm_ps2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TX_HI,
    ST_TX_LO,
    ST_TX_END,
    ST_RTS_WAIT,
    ST_RX_HI,
    ST_RX_LO,
    ST_RX_ACK,
    ST_HOLD
  } ps2_state_t;

  localparam int FRAME_LEN = 11;
  localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_BAT    = 8'hAA;
  localparam logic [7:0] BYTE_ECHO   = 8'hEE;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;
  localparam logic [7:0] BYTE_RESET  = 8'hFF;

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/relm_ps2_filter.sv
// relm_ps2_filter: WF-deep sampler; the output level only moves
// when every sample in the window agrees.
module relm_ps2_filter #(
  parameter int WF = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  logic [WF-1:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh    <= '1;
      level <= 1'b1;
    end else begin
      sh <= {sh[WF-2:0], raw};
      if (&sh) level <= 1'b1;
      else if (~|sh) level <= 1'b0;
    end
  end

endmodule

// File: rtl/relm_ps2_device.sv
// relm_ps2_device: keyboard-side PS/2 endpoint with push/pop byte ports.
// Define RELM_PS2DEV_AUTOACK_EN for automatic ACK/BAT/ECHO/RESEND replies.
module relm_ps2_device
  import relm_ps2_pkg::*;
#(
  parameter int HALF    = 2000,
  parameter int INHIBIT = 5000,
  parameter int WF      = 8
) (
  input  logic       clk,
  input  logic       rst_n_in,
  input  logic       tx_we_in,
  input  logic [7:0] tx_d_in,
  output logic       tx_retry_out,
  input  logic       rx_re_in,
  output logic [7:0] rx_q_out,
  output logic       rx_valid_out,
  output logic       rx_err_out,
  inout  wire  [1:0] ps2_inout
);

`ifdef RELM_PS2DEV_AUTOACK_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  localparam logic [12:0] T_HALF = 13'(HALF);
  localparam logic [12:0] T_MID  = 13'(HALF / 2);
  localparam logic [12:0] T_INH  = 13'(INHIBIT);
  localparam logic [12:0] T_HOLD = 13'(HALF + HALF / 4);

  ps2_state_t  state;
  logic [12:0] timer;
  logic [3:0]  bit_idx;
  logic [2:0]  extra;
  logic        clk_drv;
  logic        dat_drv;
  logic        fclk;
  logic        fdat;
  logic        fclk_q;
  logic        pending;
  logic [7:0]  tx_buf;
  logic [1:0]  auto_n;
  logic [7:0]  auto0;
  logic [7:0]  auto1;
  logic [7:0]  last_tx;
  logic [7:0]  rx_sh;
  logic        rx_par;
  logic        rx_stop;
  logic        rx_stop_err;
  logic [7:0]  cur;
  logic [10:0] frame;
  logic        half_done;
  logic        bad;

  // Reset gates the drivers directly so lines float the instant it asserts.
  assign ps2_inout[0] = (rst_n_in && clk_drv) ? 1'b0 : 1'bz;
  assign ps2_inout[1] = (rst_n_in && dat_drv) ? 1'b0 : 1'bz;

  relm_ps2_filter #(.WF(WF)) u_clk_filt (
    .clk   (clk),
    .rst_n (rst_n_in),
    .raw   (ps2_inout[0]),
    .level (fclk)
  );

  relm_ps2_filter #(.WF(WF)) u_dat_filt (
    .clk   (clk),
    .rst_n (rst_n_in),
    .raw   (ps2_inout[1]),
    .level (fdat)
  );

  assign cur          = (auto_n != 2'd0) ? auto0 : tx_buf;
  assign frame        = {1'b1, odd_par(cur), cur, 1'b0};
  assign half_done    = (timer == T_HALF - 13'd1);
  assign bad          = (rx_par != odd_par(rx_sh)) || rx_stop_err;
  assign tx_retry_out = pending || (auto_n != 2'd0);

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= ST_IDLE;
      timer        <= '0;
      bit_idx      <= '0;
      extra        <= '0;
      clk_drv      <= 1'b0;
      dat_drv      <= 1'b0;
      fclk_q       <= 1'b1;
      pending      <= 1'b0;
      tx_buf       <= '0;
      auto_n       <= '0;
      auto0        <= '0;
      auto1        <= '0;
      last_tx      <= '0;
      rx_sh        <= '0;
      rx_par       <= 1'b0;
      rx_stop      <= 1'b0;
      rx_stop_err  <= 1'b0;
      rx_q_out     <= '0;
      rx_valid_out <= 1'b0;
      rx_err_out   <= 1'b0;
    end else begin
      fclk_q <= fclk;
      if (timer != '1) timer <= timer + 13'd1;
      if (tx_we_in && !tx_retry_out) begin
        tx_buf  <= tx_d_in;
        pending <= 1'b1;
      end
      if (rx_re_in) begin
        rx_valid_out <= 1'b0;
        rx_err_out   <= 1'b0;
      end
      unique case (state)
        ST_IDLE, ST_HOLD: begin
          // timer measures how long the filtered clock has held its level
          if (fclk != fclk_q) timer <= '0;
          if (!fclk && !fdat && timer >= T_INH) begin
            state       <= ST_RTS_WAIT;
            bit_idx     <= '0;
            extra       <= '0;
            rx_stop_err <= 1'b0;
          end else if (fclk && fdat && tx_retry_out &&
                       (state == ST_IDLE || timer >= T_HOLD)) begin
            state   <= ST_TX_HI;
            timer   <= '0;
            bit_idx <= '0;
            dat_drv <= ~frame[0];
          end
        end
        ST_TX_HI: if (half_done) begin
          timer <= '0;
          if (fclk) begin
            state   <= ST_TX_LO;
            clk_drv <= 1'b1;
          end else if (bit_idx == LAST_BIT) begin
            state <= ST_TX_END;
          end else begin
            state   <= ST_HOLD;
            dat_drv <= 1'b0;
          end
        end
        ST_TX_LO: if (half_done) begin
          timer   <= '0;
          clk_drv <= 1'b0;
          if (bit_idx == LAST_BIT) begin
            state <= ST_TX_END;
          end else begin
            state   <= ST_TX_HI;
            bit_idx <= bit_idx + 4'd1;
            dat_drv <= ~frame[bit_idx + 4'd1];
          end
        end
        ST_TX_END: begin
          state   <= ST_IDLE;
          timer   <= '0;
          dat_drv <= 1'b0;
          last_tx <= cur;
          if (auto_n != 2'd0) begin
            auto0  <= auto1;
            auto_n <= auto_n - 2'd1;
          end else begin
            pending <= 1'b0;
          end
        end
        ST_RTS_WAIT: begin
          timer <= '0;
          if (fclk) begin
            state   <= ST_RX_LO;
            clk_drv <= 1'b1;
          end
        end
        ST_RX_LO: if (half_done) begin
          state   <= ST_RX_HI;
          timer   <= '0;
          clk_drv <= 1'b0;
        end
        ST_RX_HI: begin
          if (timer == T_MID) begin
            if (bit_idx < 4'd8) begin
              rx_sh <= {fdat, rx_sh[7:1]};
            end else if (bit_idx == 4'd8) begin
              rx_par <= fdat;
            end else begin
              rx_stop <= fdat;
              if (!fdat) rx_stop_err <= 1'b1;
            end
          end
          if (half_done) begin
            timer   <= '0;
            clk_drv <= 1'b1;
            if (bit_idx < 4'd9) begin
              state   <= ST_RX_LO;
              bit_idx <= bit_idx + 4'd1;
            end else if (rx_stop || extra == 3'd4) begin
              state   <= ST_RX_ACK;
              dat_drv <= 1'b1;
            end else begin
              state <= ST_RX_LO;
              extra <= extra + 3'd1;
            end
          end
        end
        ST_RX_ACK: if (half_done) begin
          state        <= ST_IDLE;
          timer        <= '0;
          clk_drv      <= 1'b0;
          dat_drv      <= 1'b0;
          rx_q_out     <= rx_sh;
          rx_valid_out <= 1'b1;
          rx_err_out   <= (rx_err_out && !rx_re_in) || bad ||
                          (rx_valid_out && !rx_re_in);
          if (AUTO_EN && !bad) begin
            unique case (1'b1)
              rx_sh == BYTE_ECHO: begin
                auto0  <= BYTE_ECHO;
                auto_n <= 2'd1;
              end
              rx_sh == BYTE_RESEND: begin
                auto0  <= last_tx;
                auto_n <= 2'd1;
              end
              rx_sh == BYTE_RESET: begin
                auto0  <= BYTE_ACK;
                auto1  <= BYTE_BAT;
                auto_n <= 2'd2;
              end
              default: begin
                auto0  <= BYTE_ACK;
                auto_n <= 2'd1;
              end
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relm_ps2_device.sv
// tb_relm_ps2_device: host-side bench for relm_ps2_device with an
// open-drain bus, a frame model and randomized bytes.
module tb_relm_ps2_device;

  localparam int HALF    = 24;
  localparam int INHIBIT = 60;
  localparam int WF      = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_we = 1'b0;
  logic [7:0] tx_d = 8'h00;
  logic       tx_retry;
  logic       rx_re = 1'b0;
  logic [7:0] rx_q;
  logic       rx_valid;
  logic       rx_err;
  wire  [1:0] ps2;
  logic       host_clk_low = 1'b0;
  logic       host_dat_low = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  assign ps2[0] = host_clk_low ? 1'b0 : 1'bz;
  assign ps2[1] = host_dat_low ? 1'b0 : 1'bz;
  pullup pu_c (ps2[0]);
  pullup pu_d (ps2[1]);

  always #5 clk = ~clk;

  relm_ps2_device #(.HALF(HALF), .INHIBIT(INHIBIT), .WF(WF)) dut (
    .clk          (clk),
    .rst_n_in     (rst_n),
    .tx_we_in     (tx_we),
    .tx_d_in      (tx_d),
    .tx_retry_out (tx_retry),
    .rx_re_in     (rx_re),
    .rx_q_out     (rx_q),
    .rx_valid_out (rx_valid),
    .rx_err_out   (rx_err),
    .ps2_inout    (ps2)
  );

  // Wire order: index k is the k-th bit seen by the receiver.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    tx_we = 1'b1;
    tx_d  = d;
    @(negedge clk);
    tx_we = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    rx_re = 1'b1;
    @(negedge clk);
    rx_re = 1'b0;
  endtask

  task automatic capture(output logic [10:0] bits, output int falls,
                         input int budget);
    logic prev;
    int   cyc;
    bits  = '1;
    falls = 0;
    cyc   = 0;
    prev  = ps2[0];
    while (falls < 11 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (prev && !ps2[0]) begin
        bits[falls] = ps2[1];
        falls++;
      end
      prev = ps2[0];
    end
  endtask

  task automatic count_falls(output int falls, input int cycles);
    logic prev;
    falls = 0;
    prev  = ps2[0];
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (prev && !ps2[0]) falls++;
      prev = ps2[0];
    end
  endtask

  task automatic host_send(input logic [7:0] d, input logic flip,
                           output int clocks, output logic ack);
    logic [10:0] f;
    logic        prev;
    int          cyc;
    f = frame_of(d);
    if (flip) f[9] = ~f[9];
    host_clk_low = 1'b1;
    repeat (INHIBIT + 20) @(negedge clk);
    host_dat_low = 1'b1;
    repeat (20) @(negedge clk);
    host_clk_low = 1'b0;
    clocks = 0;
    ack    = 1'b0;
    cyc    = 0;
    prev   = ps2[0];
    while (clocks < 11 && cyc < 40 * HALF) begin
      @(negedge clk);
      cyc++;
      if (prev && !ps2[0]) begin
        clocks++;
        host_dat_low = (clocks <= 10) ? ~f[clocks] : 1'b0;
      end
      prev = ps2[0];
    end
    host_dat_low = 1'b0;
    if (clocks == 11) begin
      repeat (HALF / 2) @(negedge clk);
      ack = !ps2[1];
      cyc = 0;
      while (ps2[0] !== 1'b1 && cyc < 4 * HALF) begin
        @(negedge clk);
        cyc++;
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (tx_retry !== 1'b0) $display("FAIL reset_retry got %b want 0", tx_retry);
    else n_pass++;
    n_chk++;
    if (rx_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", rx_valid);
    else n_pass++;
    n_chk++;
    if (rx_err !== 1'b0) $display("FAIL reset_err got %b want 0", rx_err);
    else n_pass++;
    n_chk++;
    if (rx_q !== 8'h00) $display("FAIL reset_q got %h want 00", rx_q);
    else n_pass++;
    n_chk++;
    if (ps2 !== 2'b11) $display("FAIL reset_lines got %b want 11", ps2);
    else n_pass++;
  endtask

  task automatic test_tx();
    logic [7:0]  d;
    logic [10:0] bits;
    int          falls;
    for (int t = 0; t < 4; t++) begin
      d = (t == 0) ? 8'h1C : 8'($urandom_range(0, 255));
      push(d);
      n_chk++;
      if (tx_retry !== 1'b1) $display("FAIL tx_retry_set got %b want 1", tx_retry);
      else n_pass++;
      capture(bits, falls, 40 * HALF);
      n_chk++;
      if (falls != 11) $display("FAIL tx_clocks byte %h got %0d want 11", d, falls);
      else n_pass++;
      n_chk++;
      if (bits !== frame_of(d))
        $display("FAIL tx_bits byte %h got %b want %b", d, bits, frame_of(d));
      else n_pass++;
      repeat (HALF + 4) @(negedge clk);
      n_chk++;
      if (tx_retry !== 1'b0) $display("FAIL tx_retry_clear got %b want 0", tx_retry);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a;
    logic [7:0]  b;
    logic [10:0] bits;
    int          falls;
    a = 8'($urandom_range(0, 255));
    b = ~a;
    @(negedge clk);
    tx_we = 1'b1;
    tx_d  = a;
    @(negedge clk);
    n_chk++;
    if (tx_retry !== 1'b1) $display("FAIL b2b_retry got %b want 1", tx_retry);
    else n_pass++;
    tx_d = b;
    @(negedge clk);
    tx_we = 1'b0;
    capture(bits, falls, 40 * HALF);
    n_chk++;
    if (bits !== frame_of(a) || falls != 11)
      $display("FAIL b2b_first got %b/%0d want %b/11", bits, falls, frame_of(a));
    else n_pass++;
    count_falls(falls, 20 * HALF);
    n_chk++;
    if (falls != 0) $display("FAIL b2b_ignored got %0d clocks want 0", falls);
    else n_pass++;
  endtask

  task automatic test_hold();
    logic [10:0] bits;
    logic        prev;
    int          falls;
    int          cyc;
    push(8'h5A);
    falls = 0;
    cyc   = 0;
    prev  = ps2[0];
    while (falls < 6 && cyc < 40 * HALF) begin
      @(negedge clk);
      cyc++;
      if (prev && !ps2[0]) falls++;
      prev = ps2[0];
    end
    cyc = 0;
    while (ps2[0] !== 1'b1 && cyc < 4 * HALF) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    host_clk_low = 1'b1;
    repeat (5 * HALF) @(negedge clk);
    n_chk++;
    if (ps2[1] !== 1'b1) $display("FAIL hold_data got %b want 1", ps2[1]);
    else n_pass++;
    n_chk++;
    if (tx_retry !== 1'b1) $display("FAIL hold_retry got %b want 1", tx_retry);
    else n_pass++;
    host_clk_low = 1'b0;
    capture(bits, falls, 40 * HALF);
    n_chk++;
    if (bits !== frame_of(8'h5A) || falls != 11)
      $display("FAIL hold_resend got %b/%0d want %b/11",
               bits, falls, frame_of(8'h5A));
    else n_pass++;
    repeat (HALF + 4) @(negedge clk);
    n_chk++;
    if (tx_retry !== 1'b0) $display("FAIL hold_retry_clear got %b want 0", tx_retry);
    else n_pass++;
  endtask

  task automatic test_rx();
    logic [7:0] d;
    logic       ack;
    int         clocks;
`ifdef RELM_PS2DEV_AUTOACK_EN
    logic [10:0] bits;
    int          falls;
`endif
    for (int t = 0; t < 3; t++) begin
      d = (t == 0) ? 8'hED : 8'($urandom_range(0, 8'hEC));
      host_send(d, 1'b0, clocks, ack);
      n_chk++;
      if (clocks != 11 || ack !== 1'b1)
        $display("FAIL rx_ack got %0d/%b want 11/1", clocks, ack);
      else n_pass++;
      n_chk++;
      if (rx_q !== d || rx_valid !== 1'b1 || rx_err !== 1'b0)
        $display("FAIL rx_byte got %h v%b e%b want %h v1 e0",
                 rx_q, rx_valid, rx_err, d);
      else n_pass++;
`ifdef RELM_PS2DEV_AUTOACK_EN
      capture(bits, falls, 40 * HALF);
      n_chk++;
      if (bits !== frame_of(8'hFA))
        $display("FAIL rx_autoack got %b want %b", bits, frame_of(8'hFA));
      else n_pass++;
      repeat (HALF + 4) @(negedge clk);
`endif
      pop();
    end
  endtask

  task automatic test_bad_parity();
    logic ack;
    int   clocks;
    host_send(8'hF3, 1'b1, clocks, ack);
    n_chk++;
    if (rx_q !== 8'hF3 || rx_valid !== 1'b1 || rx_err !== 1'b1)
      $display("FAIL par_flag got %h v%b e%b want f3 v1 e1",
               rx_q, rx_valid, rx_err);
    else n_pass++;
    pop();
    n_chk++;
    if (rx_valid !== 1'b0 || rx_err !== 1'b0)
      $display("FAIL par_pop got v%b e%b want v0 e0", rx_valid, rx_err);
    else n_pass++;
  endtask

  task automatic test_overrun();
    logic [7:0] a;
    logic [7:0] b;
    logic       ack;
    int         clocks;
`ifdef RELM_PS2DEV_AUTOACK_EN
    logic [10:0] bits;
    int          falls;
`endif
    a = 8'($urandom_range(0, 8'hEC));
    b = 8'($urandom_range(0, 8'hEC));
    host_send(a, 1'b0, clocks, ack);
`ifdef RELM_PS2DEV_AUTOACK_EN
    capture(bits, falls, 40 * HALF);
    repeat (HALF + 4) @(negedge clk);
`endif
    host_send(b, 1'b0, clocks, ack);
    n_chk++;
    if (rx_q !== b || rx_valid !== 1'b1 || rx_err !== 1'b1)
      $display("FAIL overrun got %h v%b e%b want %h v1 e1",
               rx_q, rx_valid, rx_err, b);
    else n_pass++;
`ifdef RELM_PS2DEV_AUTOACK_EN
    capture(bits, falls, 40 * HALF);
    repeat (HALF + 4) @(negedge clk);
`endif
    pop();
  endtask

  task automatic test_autoack();
    logic ack;
    int   clocks;
    int   falls;
`ifdef RELM_PS2DEV_AUTOACK_EN
    logic [10:0] bits;
    host_send(8'hFF, 1'b0, clocks, ack);
    capture(bits, falls, 40 * HALF);
    n_chk++;
    if (bits !== frame_of(8'hFA))
      $display("FAIL auto_fa got %b want %b", bits, frame_of(8'hFA));
    else n_pass++;
    n_chk++;
    if (tx_retry !== 1'b1) $display("FAIL auto_retry got %b want 1", tx_retry);
    else n_pass++;
    capture(bits, falls, 60 * HALF);
    n_chk++;
    if (bits !== frame_of(8'hAA))
      $display("FAIL auto_aa got %b want %b", bits, frame_of(8'hAA));
    else n_pass++;
`else
    host_send(8'hFF, 1'b0, clocks, ack);
    count_falls(falls, 30 * HALF);
    n_chk++;
    if (falls != 0) $display("FAIL auto_none got %0d clocks want 0", falls);
    else n_pass++;
`endif
    repeat (HALF + 4) @(negedge clk);
    n_chk++;
    if (tx_retry !== 1'b0) $display("FAIL auto_retry_end got %b want 0", tx_retry);
    else n_pass++;
    pop();
  endtask

  task automatic test_mid_reset();
    logic prev;
    int   falls;
    int   cyc;
    push(8'($urandom_range(0, 255)));
    falls = 0;
    cyc   = 0;
    prev  = ps2[0];
    while (falls < 7 && cyc < 40 * HALF) begin
      @(negedge clk);
      cyc++;
      if (prev && !ps2[0]) falls++;
      prev = ps2[0];
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (ps2[0] !== 1'b0) $display("FAIL mid_clk_low got %b want 0", ps2[0]);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (ps2 !== 2'b11) $display("FAIL mid_release got %b want 11", ps2);
    else n_pass++;
    n_chk++;
    if (tx_retry !== 1'b0) $display("FAIL mid_retry got %b want 0", tx_retry);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    count_falls(falls, 30 * HALF);
    n_chk++;
    if (falls != 0) $display("FAIL mid_quiet got %0d clocks want 0", falls);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_hold();
    test_rx();
    test_bad_parity();
    test_overrun();
    test_autoack();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
